// File: rtl/dmac_burst_scheduler.sv
// ---------------------------------------------------------------------------
// dmac_burst_scheduler
// Multi-channel DMA burst scheduler. Each channel holds one copy descriptor
// (source, destination, remaining beats). Busy channels are served
// round-robin, one AXI INCR burst per grant. Each burst is clipped to
// MAX_BURST_LEN and to the 4 KB page of both the source and the destination.
// Bursts are presented through a single registered valid/ready output slot.
// Completion is signalled by a one-cycle per-channel done pulse.
// ADDR_WD must be at least 16 so that the 12-bit page offset exists.
// ---------------------------------------------------------------------------
module dmac_burst_scheduler #(
    parameter  int ADDR_WD       = 32,
    parameter  int DATA_WD       = 32,
    parameter  int CHANNEL_COUNT = 4,
    parameter  int MAX_BURST_LEN = 16,
    localparam int CH_WD         = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     cmd_valid,
    input  logic [CH_WD-1:0]         cmd_chan,
    input  logic [ADDR_WD-1:0]       cmd_src_addr,
    input  logic [ADDR_WD-1:0]       cmd_dst_addr,
    input  logic [ADDR_WD-1:0]       cmd_len,
    output logic                     cmd_ready,

    output logic                     burst_valid,
    output logic [CH_WD-1:0]         burst_chan,
    output logic [ADDR_WD-1:0]       burst_src_addr,
    output logic [ADDR_WD-1:0]       burst_dst_addr,
    output logic [7:0]               burst_len,
    output logic                     burst_last,
    input  logic                     burst_ready,

    output logic [CHANNEL_COUNT-1:0] chan_busy,
    output logic [CHANNEL_COUNT-1:0] done_pulse
);

    localparam int          BYTES   = DATA_WD / 8;
    localparam int          BEAT_SH = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam logic [12:0] PAGE    = 13'd4096;
    localparam logic [12:0] MAX_B   = 13'(MAX_BURST_LEN);

    // Per-channel descriptor state
    logic [CHANNEL_COUNT-1:0] r_busy;
    logic [ADDR_WD-1:0]       r_src [CHANNEL_COUNT];
    logic [ADDR_WD-1:0]       r_dst [CHANNEL_COUNT];
    logic [ADDR_WD-1:0]       r_rem [CHANNEL_COUNT];

    // Arbitration pointer and output slot
    logic [CH_WD-1:0]         r_rr_ptr;
    logic                     r_bvalid;
    logic [CH_WD-1:0]         r_bchan;
    logic [ADDR_WD-1:0]       r_bsrc;
    logic [ADDR_WD-1:0]       r_bdst;
    logic [7:0]               r_blen;
    logic                     r_blast;
    logic [CHANNEL_COUNT-1:0] r_done;

    // Command side
    logic                     w_cmd_ready;
    logic [ADDR_WD-1:0]       w_cmd_beats;
    logic                     w_cmd_zero;
    logic                     w_accept;

    // Grant side
    logic                     w_found;
    logic [CH_WD-1:0]         w_gnt;
    logic [CH_WD-1:0]         w_rr_next;
    logic [ADDR_WD-1:0]       w_sel_src;
    logic [ADDR_WD-1:0]       w_sel_dst;
    logic [ADDR_WD-1:0]       w_sel_rem;
    logic [12:0]              w_src_room;
    logic [12:0]              w_dst_room;
    logic [12:0]              w_rem_clip;
    logic [12:0]              w_beats13;
    logic [8:0]               w_beats;
    logic [ADDR_WD-1:0]       w_step;
    logic                     w_last;
    logic                     w_slot_free;
    logic                     w_load;
    logic                     w_hs;
    logic [CHANNEL_COUNT-1:0] w_done_next;

    // Command acceptance: a channel takes a new descriptor only when idle.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_cmd_ready = 1'b0;
        if (int'(cmd_chan) < CHANNEL_COUNT) begin
            w_cmd_ready = !r_busy[cmd_chan];
        end
    end

    assign w_cmd_beats = cmd_len >> BEAT_SH;
    assign w_cmd_zero  = (w_cmd_beats == '0);
    assign w_accept    = cmd_valid && w_cmd_ready;

    // Round-robin search: first busy channel at or after r_rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            idx = (int'(r_rr_ptr) + i) % CHANNEL_COUNT;
            if (!w_found && r_busy[idx]) begin
                w_found = 1'b1;
                w_gnt   = CH_WD'(idx);
            end
        end
    end

    assign w_rr_next = (int'(w_gnt) == CHANNEL_COUNT - 1) ? '0 : w_gnt + 1'b1;

    assign w_sel_src = r_src[w_gnt];
    assign w_sel_dst = r_dst[w_gnt];
    assign w_sel_rem = r_rem[w_gnt];

    // Burst size: smallest of remaining beats, the burst cap, and the beats
    // left in the current 4 KB page on each side. The page distance uses a
    // 13-bit subtraction so a page-aligned address yields a full 4096.
    always_comb begin
        w_src_room = (PAGE - {1'b0, w_sel_src[11:0]}) >> BEAT_SH;
        w_dst_room = (PAGE - {1'b0, w_sel_dst[11:0]}) >> BEAT_SH;
        w_rem_clip = (w_sel_rem > ADDR_WD'(4096)) ? PAGE : w_sel_rem[12:0];
        w_beats13  = w_rem_clip;
        if (MAX_B < w_beats13) begin
            w_beats13 = MAX_B;
        end
        if (w_src_room < w_beats13) begin
            w_beats13 = w_src_room;
        end
        if (w_dst_room < w_beats13) begin
            w_beats13 = w_dst_room;
        end
    end

    assign w_beats     = w_beats13[8:0];
    assign w_step      = ADDR_WD'(w_beats) << BEAT_SH;
    assign w_last      = (ADDR_WD'(w_beats) == w_sel_rem);
    assign w_slot_free = !r_bvalid || burst_ready;
    assign w_load      = w_slot_free && w_found;
    assign w_hs        = r_bvalid && burst_ready;

    // Done sources: zero-beat command accept and last-burst handshake.
    always_comb begin
        w_done_next = '0;
        if (w_accept && w_cmd_zero) begin
            w_done_next[cmd_chan] = 1'b1;
        end
        if (w_hs && r_blast) begin
            w_done_next[r_bchan] = 1'b1;
        end
    end

    // Control state: busy flags, arbitration pointer, output slot, done pulses.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_busy   <= '0;
            r_rr_ptr <= '0;
            r_bvalid <= 1'b0;
            r_bchan  <= '0;
            r_bsrc   <= '0;
            r_bdst   <= '0;
            r_blen   <= '0;
            r_blast  <= 1'b0;
            r_done   <= '0;
        end else begin
            if (w_accept) begin
                r_busy[cmd_chan] <= !w_cmd_zero;
            end
            if (w_load && w_last) begin
                r_busy[w_gnt] <= 1'b0;
            end
            if (w_slot_free) begin
                r_bvalid <= w_found;
                if (w_found) begin
                    r_bchan  <= w_gnt;
                    r_bsrc   <= w_sel_src;
                    r_bdst   <= w_sel_dst;
                    r_blen   <= 8'(w_beats - 9'd1);
                    r_blast  <= w_last;
                    r_rr_ptr <= w_rr_next;
                end
            end
            r_done <= w_done_next;
        end
    end

    // Descriptor storage: loaded on accept, advanced on grant. Accept needs
    // an idle channel and grant a busy one, so both never hit the same entry.
    always_ff @(posedge clk) begin
        // NOTE: the descriptor arrays are not reset; r_busy qualifies their
        // contents, so reset logic on them would buy nothing.
        if (w_accept) begin
            r_src[cmd_chan] <= cmd_src_addr;
            r_dst[cmd_chan] <= cmd_dst_addr;
            r_rem[cmd_chan] <= w_cmd_beats;
        end
        if (w_load) begin
            r_src[w_gnt] <= w_sel_src + w_step;
            r_dst[w_gnt] <= w_sel_dst + w_step;
            r_rem[w_gnt] <= w_sel_rem - ADDR_WD'(w_beats);
        end
    end

    assign cmd_ready      = w_cmd_ready;
    assign burst_valid    = r_bvalid;
    assign burst_chan     = r_bchan;
    assign burst_src_addr = r_bsrc;
    assign burst_dst_addr = r_bdst;
    assign burst_len      = r_blen;
    assign burst_last     = r_blast;
    assign chan_busy      = r_busy;
    assign done_pulse     = r_done;

endmodule

// File: tb/tb_dmac_burst_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dmac_burst_scheduler
// Scoreboard bench: a reference splitter fills per-channel burst lists, the
// lists are interleaved round-robin into an expected queue, and a negedge
// monitor compares every presented burst and every done pulse.
// ---------------------------------------------------------------------------
module tb_dmac_burst_scheduler;

    localparam int AW   = 32;
    localparam int CH_N = 4;
    localparam int CHW  = 2;

    typedef struct packed {
        logic [CHW-1:0] chan;
        logic [AW-1:0]  src;
        logic [AW-1:0]  dst;
        logic [7:0]     len;
        logic           last;
    } burst_t;

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic [CHW-1:0]  cmd_chan;
    logic [AW-1:0]   cmd_src_addr;
    logic [AW-1:0]   cmd_dst_addr;
    logic [AW-1:0]   cmd_len;
    logic            cmd_ready;
    logic            burst_valid;
    logic [CHW-1:0]  burst_chan;
    logic [AW-1:0]   burst_src_addr;
    logic [AW-1:0]   burst_dst_addr;
    logic [7:0]      burst_len;
    logic            burst_last;
    logic            burst_ready;
    logic [CH_N-1:0] chan_busy;
    logic [CH_N-1:0] done_pulse;

    burst_t          exp_q[$];
    burst_t          ch_q[CH_N][$];
    logic [CH_N-1:0] exp_done;
    int              done_cnt[CH_N];
    int              snap[CH_N];
    int              n_cmp;
    int              n_err;

    dmac_burst_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_chan       (cmd_chan),
        .cmd_src_addr   (cmd_src_addr),
        .cmd_dst_addr   (cmd_dst_addr),
        .cmd_len        (cmd_len),
        .cmd_ready      (cmd_ready),
        .burst_valid    (burst_valid),
        .burst_chan     (burst_chan),
        .burst_src_addr (burst_src_addr),
        .burst_dst_addr (burst_dst_addr),
        .burst_len      (burst_len),
        .burst_last     (burst_last),
        .burst_ready    (burst_ready),
        .chan_busy      (chan_busy),
        .done_pulse     (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference splitter: same clipping rules, written as a plain loop.
    task automatic model_split(input int ch, input logic [AW-1:0] src,
                               input logic [AW-1:0] dst, input logic [AW-1:0] len);
        logic [AW-1:0] rem;
        int            b;
        int            rs;
        int            rd;
        burst_t        e;
        rem = len >> 2;
        while (rem != 0) begin
            b  = (rem > 16) ? 16 : int'(rem);
            rs = (4096 - int'(src[11:0])) / 4;
            rd = (4096 - int'(dst[11:0])) / 4;
            if (rs < b) b = rs;
            if (rd < b) b = rd;
            e.chan = CHW'(ch);
            e.src  = src;
            e.dst  = dst;
            e.len  = 8'(b - 1);
            e.last = (32'(b) == rem);
            ch_q[ch].push_back(e);
            src = src + 32'(b * 4);
            dst = dst + 32'(b * 4);
            rem = rem - 32'(b);
        end
    endtask

    // Interleave the per-channel lists one burst per channel per round.
    task automatic merge_rr();
        bit any;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int c = 0; c < CH_N; c++) begin
                if (ch_q[c].size() > 0) begin
                    exp_q.push_back(ch_q[c].pop_front());
                    any = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the accepting edge.
    task automatic send_cmd(input int ch, input logic [AW-1:0] src,
                            input logic [AW-1:0] dst, input logic [AW-1:0] len);
        cmd_valid    = 1'b1;
        cmd_chan     = CHW'(ch);
        cmd_src_addr = src;
        cmd_dst_addr = dst;
        cmd_len      = len;
        @(negedge clk);
        check("cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!burst_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!burst_valid) check("valid_timeout", burst_valid, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_done(input string tag, input int ch, input int want);
        check(tag, done_cnt[ch] - snap[ch], want);
    endtask

    // Monitor: compare the presented burst with the queue head every cycle it
    // is valid, pop on handshake, and predict done pulses one cycle ahead.
    always @(negedge clk) begin
        burst_t obs;
        if (rst) begin
            exp_done = '0;
        end else begin
            if (exp_done != '0 || done_pulse != '0) begin
                check("done_pulse", done_pulse, exp_done);
            end
            for (int c = 0; c < CH_N; c++) begin
                if (done_pulse[c]) done_cnt[c]++;
            end
            exp_done = '0;
            if (burst_valid) begin
                obs = '{burst_chan, burst_src_addr, burst_dst_addr, burst_len, burst_last};
                if (exp_q.size() == 0) begin
                    check("unexpected_burst", burst_valid, 0);
                end else begin
                    check(burst_ready ? "burst" : "burst_held", obs, exp_q[0]);
                    if (burst_ready) begin
                        if (exp_q[0].last) exp_done[exp_q[0].chan] = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (cmd_valid && cmd_ready && (cmd_len >> 2) == 0) begin
                exp_done[cmd_chan] = 1'b1;
            end
        end
    end

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        exp_done     = '0;
        for (int c = 0; c < CH_N; c++) done_cnt[c] = 0;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_chan     = '0;
        cmd_src_addr = '0;
        cmd_dst_addr = '0;
        cmd_len      = '0;
        burst_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {burst_valid, burst_chan, burst_src_addr, burst_dst_addr,
                                burst_len, burst_last, chan_busy, done_pulse}, '0);
        check("reset_cmd_ready", cmd_ready, 1);
        tick();
        rst = 1'b0;

        // Single channel, four full bursts, with latency check
        snap = done_cnt;
        burst_ready = 1'b1;
        model_split(0, 32'h1000, 32'h2000, 256);
        merge_rr();
        tick();
        send_cmd(0, 32'h1000, 32'h2000, 256);
        @(negedge clk);
        check("lat_busy", chan_busy, 4'b0001);
        check("lat_not_ready", cmd_ready, 0);
        check("lat_no_valid_yet", burst_valid, 0);
        @(negedge clk);
        check("lat_valid_n2", burst_valid, 1);
        drain();
        check_done("done_t1_ch0", 0, 1);

        // Source 4 KB split
        snap = done_cnt;
        model_split(0, 32'h0FF0, 32'h5000, 64);
        merge_rr();
        tick();
        send_cmd(0, 32'h0FF0, 32'h5000, 64);
        drain();
        check_done("done_t2_ch0", 0, 1);

        // Destination boundary dominates
        snap = done_cnt;
        model_split(0, 32'h0000, 32'h1FF8, 32);
        merge_rr();
        tick();
        send_cmd(0, 32'h0000, 32'h1FF8, 32);
        drain();
        check_done("done_t3_ch0", 0, 1);

        // Round-robin across three channels, commands back-to-back
        snap = done_cnt;
        model_split(0, 32'h0001_0000, 32'h0002_0000, 128);
        model_split(1, 32'h0003_0000, 32'h0004_0000, 128);
        model_split(2, 32'h0005_0000, 32'h0006_0000, 128);
        merge_rr();
        tick();
        send_cmd(0, 32'h0001_0000, 32'h0002_0000, 128);
        send_cmd(1, 32'h0003_0000, 32'h0004_0000, 128);
        send_cmd(2, 32'h0005_0000, 32'h0006_0000, 128);
        drain();
        check_done("done_rr_ch0", 0, 1);
        check_done("done_rr_ch1", 1, 1);
        check_done("done_rr_ch2", 2, 1);

        // Backpressure hold plus zero-length command on channel 3
        snap = done_cnt;
        burst_ready = 1'b0;
        model_split(1, 32'h0000_8000, 32'h0000_9000, 128);
        merge_rr();
        tick();
        send_cmd(1, 32'h0000_8000, 32'h0000_9000, 128);
        wait_valid();
        repeat (5) @(negedge clk);
        check("held_valid", burst_valid, 1);
        tick();
        send_cmd(3, 32'h0000_A000, 32'h0000_B000, 0);
        @(negedge clk);
        check("zero_done3", done_pulse[3], 1);
        check("zero_ready3", cmd_ready, 1);
        check("zero_busy", chan_busy, 4'b0010);
        tick();
        burst_ready = 1'b1;
        drain();
        check_done("done_bp_ch1", 1, 1);
        check_done("done_bp_ch3", 3, 1);

        // Reset after two of four bursts
        snap = done_cnt;
        burst_ready = 1'b0;
        model_split(0, 32'h0003_0000, 32'h0004_0000, 256);
        merge_rr();
        tick();
        send_cmd(0, 32'h0003_0000, 32'h0004_0000, 256);
        wait_valid();
        for (int k = 0; k < 2; k++) begin
            tick();
            burst_ready = 1'b1;
            tick();
            burst_ready = 1'b0;
        end
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_mid_outputs", {burst_valid, burst_chan, burst_src_addr, burst_dst_addr,
                                  burst_len, burst_last, chan_busy, done_pulse}, '0);
        check("rst_mid_left", exp_q.size(), 2);
        exp_q.delete();
        tick();
        rst = 1'b0;
        burst_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_idle_busy", chan_busy, 0);
        check_done("rst_no_done_ch0", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
